// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        RELEASE = 2'd0,
        IDLE    = 2'd1,
        BUS     = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker: on contention the port not granted last wins.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = PORT_D;
        end else begin
            grant_id = PORT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory bus between the fetch port and the load/store port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              mem_req,
    input  logic              mem_ready,
    output logic              we
);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   i_rdata_reg, i_rdata_next;
    logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
    logic                we_reg, we_next;
    logic                mem_req_reg, mem_req_next;
    logic                i_ack_reg, i_ack_next;
    logic                d_ack_reg, d_ack_next;
    logic                grant_reg, grant_next;
    logic                last_grant_reg, last_grant_next;
    logic                pick_valid, pick_id;

    arb_rr2 u_pick (
        .req0        (i_req),
        .req1        (d_req),
        .last_grant  (last_grant_reg),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= RELEASE;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            i_rdata_reg    <= '0;
            d_rdata_reg    <= '0;
            we_reg         <= 1'b0;
            mem_req_reg    <= 1'b0;
            i_ack_reg      <= 1'b0;
            d_ack_reg      <= 1'b0;
            grant_reg      <= PORT_I;
            last_grant_reg <= PORT_I;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            i_rdata_reg    <= i_rdata_next;
            d_rdata_reg    <= d_rdata_next;
            we_reg         <= we_next;
            mem_req_reg    <= mem_req_next;
            i_ack_reg      <= i_ack_next;
            d_ack_reg      <= d_ack_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        i_rdata_next    = i_rdata_reg;
        d_rdata_next    = d_rdata_reg;
        we_next         = we_reg;
        mem_req_next    = mem_req_reg;
        i_ack_next      = 1'b0;
        d_ack_next      = 1'b0;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;

        case (state_reg)
            // mem_ready lags mem_req by a cycle; wait for it to drop so the stale high is not a response
            RELEASE: begin
                mem_req_next = 1'b0;
                we_next      = 1'b0;
                if (!mem_ready) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (pick_valid) begin
                    grant_next   = pick_id;
                    mem_req_next = 1'b1;
                    state_next   = BUS;
                    if (pick_id == PORT_D) begin
                        addr_next  = d_addr;
                        we_next    = d_we;
                        wdata_next = d_wdata;
                    end else begin
                        addr_next  = i_addr;
                        we_next    = 1'b0;
                    end
                end
            end
            BUS: begin
                if (mem_ready) begin
                    if (grant_reg == PORT_D) begin
                        d_ack_next = 1'b1;
                        if (!we_reg) begin
                            d_rdata_next = data;
                        end
                    end else begin
                        i_ack_next   = 1'b1;
                        i_rdata_next = data;
                    end
                    mem_req_next    = 1'b0;
                    we_next         = 1'b0;
                    last_grant_next = grant_reg;
                    state_next      = RELEASE;
                end
            end
            default: begin
                state_next   = RELEASE;
                mem_req_next = 1'b0;
                we_next      = 1'b0;
            end
        endcase
    end

    assign data    = we_reg ? wdata_reg : {DATA_W{1'bz}};
    assign addr    = addr_reg;
    assign we      = we_reg;
    assign mem_req = mem_req_reg;
    assign i_ack   = i_ack_reg;
    assign d_ack   = d_ack_reg;
    assign i_rdata = i_rdata_reg;
    assign d_rdata = d_rdata_reg;

endmodule
